my_aes_decipher: RTL and testbench

Iterative AES-128 inverse cipher. It processes one round per clock and is the decrypt counterpart of the existing one-round-per-cycle encipher. It shares the same externally loaded 11-entry round-key memory interface, so the host's key-schedule loader can drive either block. It converts a 128-bit ciphertext block to plaintext in 11 processing cycles after acceptance.

---
 rtl/my_aes_decipher_pkg.sv | 96 +++++++++
 rtl/my_aes_decipher_inv_sbox.sv | 45 ++++
 rtl/my_aes_decipher.sv | 100 ++++++++++
 tb/tb_my_aes_decipher.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/my_aes_decipher_pkg.sv
// Shared AES-128 definitions: round count, control-state encoding, GF(2^8)
// helpers and the column-wise (inverse) ShiftRows / MixColumns transforms.
package my_aes_decipher_pkg;

    localparam int AES128_ROUNDS = 10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        INIT  = 2'd1,
        ROUND = 2'd2
    } state_e;

    function automatic logic [7:0] gm2(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gm3(input logic [7:0] x);
        return gm2(x) ^ x;
    endfunction

    function automatic logic [7:0] gm9(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ x;
    endfunction

    function automatic logic [7:0] gm11(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ gm2(x) ^ x;
    endfunction

    function automatic logic [7:0] gm13(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ gm2(gm2(x)) ^ x;
    endfunction

    function automatic logic [7:0] gm14(input logic [7:0] x);
        return gm2(gm2(gm2(x))) ^ gm2(gm2(x)) ^ gm2(x);
    endfunction

    // Byte i of a block is bits [127-8i -: 8]; column c holds bytes 4c..4c+3.
    function automatic logic [127:0] shiftrows(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c+r)%4)+r) -: 8];
            end
        end
        return y;
    endfunction

    function automatic logic [127:0] invshiftrows(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                y[127-8*(4*c+r) -: 8] = x[127-8*(4*((c-r+4)%4)+r) -: 8];
            end
        end
        return y;
    endfunction

    function automatic logic [31:0] mixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {gm2(b0) ^ gm3(b1) ^ b2      ^ b3,
                b0      ^ gm2(b1) ^ gm3(b2) ^ b3,
                b0      ^ b1      ^ gm2(b2) ^ gm3(b3),
                gm3(b0) ^ b1      ^ b2      ^ gm2(b3)};
    endfunction

    function automatic logic [31:0] invmixw(input logic [31:0] w);
        logic [7:0] b0, b1, b2, b3;
        {b0, b1, b2, b3} = w;
        return {gm14(b0) ^ gm11(b1) ^ gm13(b2) ^ gm9(b3),
                gm9(b0)  ^ gm14(b1) ^ gm11(b2) ^ gm13(b3),
                gm13(b0) ^ gm9(b1)  ^ gm14(b2) ^ gm11(b3),
                gm11(b0) ^ gm13(b1) ^ gm9(b2)  ^ gm14(b3)};
    endfunction

    function automatic logic [127:0] mixcolumns(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            y[127-32*c -: 32] = mixw(x[127-32*c -: 32]);
        end
        return y;
    endfunction

    function automatic logic [127:0] invmixcolumns(input logic [127:0] x);
        logic [127:0] y;
        y = '0;
        for (int c = 0; c < 4; c++) begin
            y[127-32*c -: 32] = invmixw(x[127-32*c -: 32]);
        end
        return y;
    endfunction

endpackage

// File: rtl/my_aes_decipher_inv_sbox.sv
// 16-byte parallel AES inverse S-box: inverse affine transform followed by
// the multiplicative inverse in GF(2^8), computed as x^254.
module aes_inv_sbox (
    input  logic [127:0] in_block,
    output logic [127:0] out_block
);
    import my_aes_decipher_pkg::*;

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ aa;
            aa = gm2(aa);
        end
        return p;
    endfunction

    // x^254 = x^2 * x^4 * ... * x^128; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] r;
        sq = x;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gf_mul(sq, sq);
            r  = gf_mul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] inv_affine(input logic [7:0] b);
        return {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
    endfunction

    always_comb begin
        out_block = '0;
        for (int i = 0; i < 16; i++) begin
            out_block[127-8*i -: 8] = gf_inv(inv_affine(in_block[127-8*i -: 8]));
        end
    end

endmodule

// File: rtl/my_aes_decipher.sv
// Iterative AES-128 inverse cipher, one round per clock, decrypting with an
// externally loaded 11-entry round-key memory.
module my_aes_decipher #(
    parameter int AES128_ROUNDS = my_aes_decipher_pkg::AES128_ROUNDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         next,
    input  logic [3:0]   init_round,
    input  logic [127:0] init_roundkey,
    input  logic         init_roundkey_valid,
    input  logic [127:0] block,
    output logic [127:0] decblock,
    output logic         result_valid,
    output logic         is_idle
);
    import my_aes_decipher_pkg::*;

    state_e       state_q, state_d;
    logic [3:0]   round_q, round_d;
    logic [127:0] decblock_q, decblock_d;
    logic         result_valid_q, result_valid_d;
    logic [127:0] key_q [AES128_ROUNDS+1];
    logic [127:0] key_d [AES128_ROUNDS+1];

    logic [127:0] isr_w;
    logic [127:0] isb_w;
    logic [127:0] ark_w;

    assign isr_w = invshiftrows(decblock_q);

    aes_inv_sbox u_inv_sbox (
        .in_block  (isr_w),
        .out_block (isb_w)
    );

    assign ark_w = isb_w ^ key_q[round_q];

    // Key writes are only honoured while idle so a running block never sees a key change.
    always_comb begin
        key_d = key_q;
        if (state_q == IDLE && init_roundkey_valid && int'(init_round) <= AES128_ROUNDS) begin
            key_d[init_round] = init_roundkey;
        end
    end

    always_comb begin
        state_d        = state_q;
        round_d        = round_q;
        decblock_d     = decblock_q;
        result_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (next) begin
                    decblock_d = block;
                    state_d    = INIT;
                end
            end
            INIT: begin
                decblock_d = decblock_q ^ key_q[AES128_ROUNDS];
                round_d    = 4'(AES128_ROUNDS - 1);
                state_d    = ROUND;
            end
            ROUND: begin
                if (round_q == 4'd0) begin
                    decblock_d     = ark_w;
                    result_valid_d = 1'b1;
                    state_d        = IDLE;
                end else begin
                    decblock_d = invmixcolumns(ark_w);
                    round_d    = round_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= IDLE;
            round_q        <= 4'd0;
            decblock_q     <= '0;
            result_valid_q <= 1'b0;
            for (int i = 0; i <= AES128_ROUNDS; i++) begin
                key_q[i] <= '0;
            end
        end else begin
            state_q        <= state_d;
            round_q        <= round_d;
            decblock_q     <= decblock_d;
            result_valid_q <= result_valid_d;
            key_q          <= key_d;
        end
    end

    assign decblock     = decblock_q;
    assign result_valid = result_valid_q;
    assign is_idle      = (state_q == IDLE);

endmodule

// File: tb/tb_my_aes_decipher.sv
// Scoreboard bench for my_aes_decipher: a textbook AES-128 model predicts
// each plaintext and a monitor checks value, latency and pulse on result_valid.
module tb_my_aes_decipher;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         next = 1'b0;
    logic [3:0]   init_round = 4'd0;
    logic [127:0] init_roundkey = '0;
    logic         init_roundkey_valid = 1'b0;
    logic [127:0] block = '0;
    logic [127:0] decblock;
    logic         result_valid;
    logic         is_idle;

    my_aes_decipher dut (
        .clk                 (clk),
        .rst                 (rst),
        .next                (next),
        .init_round          (init_round),
        .init_roundkey       (init_roundkey),
        .init_roundkey_valid (init_roundkey_valid),
        .block               (block),
        .decblock            (decblock),
        .result_valid        (result_valid),
        .is_idle             (is_idle)
    );

    always #5 clk = ~clk;

    localparam logic [127:0] C_KEY = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] C_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] C_PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] B_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] B_CT  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] B_PT  = 128'h3243f6a8885a308d313198a2e0370734;

    typedef struct {
        logic [127:0] pt;
        int           due;
    } exp_t;

    exp_t         sbq[$];
    int           cyc = 0;
    int           n_cmp = 0;
    int           n_fail = 0;
    logic [7:0]   sb [256];
    logic [7:0]   isb [256];
    logic [127:0] mk [11];
    logic [127:0] dk [11];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    function automatic void chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // ---------------- reference model ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p ^= a;
            a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, s;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
            sb[x]  = s;
            isb[s] = 8'(x);
        end
    endtask

    task automatic expand(input logic [127:0] k);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc;
        rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r < 11; r++) mk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    // FIPS-197 InvCipher on a 4x4 state, using the key memory contents in dk.
    function automatic logic [127:0] model_dec(input logic [127:0] ct);
        logic [7:0]   s [4][4];
        logic [7:0]   t [4][4];
        logic [7:0]   col [4];
        logic [7:0]   m [4];
        logic [127:0] out;
        m = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                s[r][c] = ct[127-8*(r+4*c) -: 8] ^ dk[10][127-8*(r+4*c) -: 8];
        for (int rnd = 9; rnd >= 0; rnd--) begin
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    t[r][c] = s[r][(c-r+4)%4];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++)
                    s[r][c] = isb[t[r][c]] ^ dk[rnd][127-8*(r+4*c) -: 8];
            if (rnd > 0) begin
                for (int c = 0; c < 4; c++) begin
                    for (int j = 0; j < 4; j++) col[j] = s[j][c];
                    for (int r = 0; r < 4; r++) begin
                        s[r][c] = 8'h00;
                        for (int j = 0; j < 4; j++) s[r][c] ^= gmul(m[(j-r+4)%4], col[j]);
                    end
                end
            end
        end
        out = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                out[127-8*(r+4*c) -: 8] = s[r][c];
        return out;
    endfunction

    // ---------------- monitor ----------------
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (!rst && result_valid) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_result_valid: got 1 expected 0 (cycle %0d)", cyc);
            end else begin
                e = sbq.pop_front();
                chk("plaintext", decblock, e.pt);
                chk("latency", 128'(cyc), 128'(e.due));
                chk("idle_with_result", 128'(is_idle), 128'd1);
            end
        end
    end

    // ---------------- stimulus helpers (all start and end at posedge+1) ----------------
    task automatic load_key(input int idx, input logic [127:0] k);
        init_roundkey_valid = 1'b1;
        init_round          = 4'(idx);
        init_roundkey       = k;
        if (idx <= 10) dk[idx] = k;
        @(posedge clk); #1;
        init_roundkey_valid = 1'b0;
    endtask

    task automatic load_all(input logic [127:0] k);
        expand(k);
        for (int r = 0; r < 11; r++) load_key(r, mk[r]);
    endtask

    task automatic issue(input logic [127:0] ct, input logic [127:0] pt);
        next  = 1'b1;
        block = ct;
        sbq.push_back('{pt, cyc + 12});
        @(posedge clk); #1;
        next = 1'b0;
    endtask

    task automatic wait_rv();
        bit seen = 0;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(posedge clk); #1;
            if (result_valid) seen = 1;
        end
        if (!seen) chk("wait_result_timeout", 128'd0, 128'd1);
    endtask

    task automatic wait_idle();
        bit done = 0;
        for (int i = 0; i < 40 && !done; i++) begin
            @(posedge clk); #1;
            if (sbq.size() == 0 && is_idle && !result_valid) done = 1;
        end
        if (!done) chk("drain_timeout", 128'(sbq.size()), 128'd0);
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // ---------------- test sequence ----------------
    initial begin
        logic [127:0] ct, hold;
        build_sbox();
        for (int r = 0; r < 11; r++) dk[r] = '0;

        #2 rst = 1'b1;
        #1;
        chk("reset_decblock", decblock, '0);
        chk("reset_result_valid", 128'(result_valid), 128'd0);
        chk("reset_is_idle", 128'(is_idle), 128'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // C.1 vector, then back-to-back C.1 in the result cycle
        load_all(C_KEY);
        chk("model_c1", model_dec(C_CT), C_PT);
        issue(C_CT, C_PT);
        wait_rv();
        issue(C_CT, C_PT);
        wait_idle();

        // Appendix B vector, then back-to-back random block under the same keys
        load_all(B_KEY);
        issue(B_CT, B_PT);
        wait_rv();
        ct = rnd128();
        issue(ct, model_dec(ct));
        wait_idle();

        // busy protection: next and key write during a run are ignored
        load_all(C_KEY);
        issue(C_CT, C_PT);
        repeat (2) @(posedge clk); #1;
        next = 1'b1; block = rnd128();
        init_roundkey_valid = 1'b1; init_round = 4'd5; init_roundkey = '0;
        @(posedge clk); #1;
        next = 1'b0; init_roundkey_valid = 1'b0;
        wait_idle();
        issue(C_CT, C_PT);
        wait_idle();

        // key write and next at the same edge: new key[10] is used
        load_key(10, '0);
        next = 1'b1; block = C_CT;
        init_roundkey_valid = 1'b1; init_round = 4'd10; init_roundkey = mk[10];
        dk[10] = mk[10];
        sbq.push_back('{C_PT, cyc + 12});
        @(posedge clk); #1;
        next = 1'b0; init_roundkey_valid = 1'b0;
        wait_idle();

        // reset mid-operation, at round 5
        issue(C_CT, C_PT);
        repeat (5) @(posedge clk); #1;
        rst = 1'b1;
        sbq.delete();
        for (int r = 0; r < 11; r++) dk[r] = '0;
        #1;
        chk("abort_decblock", decblock, '0);
        chk("abort_is_idle", 128'(is_idle), 128'd1);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (15) @(posedge clk); #1;
        ct = rnd128();
        issue(ct, model_dec(ct));
        wait_idle();
        load_all(C_KEY);
        issue(C_CT, C_PT);
        wait_idle();

        // idle hold and out-of-range key writes
        hold = decblock;
        load_key(11, {4{32'hdeadbeef}});
        load_key(15, {4{32'hcafef00d}});
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            if (i % 5 == 0) chk("idle_hold", decblock, hold);
        end
        chk("idle_no_result", 128'(result_valid), 128'd0);
        issue(C_CT, C_PT);
        wait_idle();

        // random keys, back-to-back random ciphertexts
        for (int k = 0; k < 5; k++) begin
            load_all(rnd128());
            ct = rnd128();
            issue(ct, model_dec(ct));
            wait_rv();
            ct = rnd128();
            issue(ct, model_dec(ct));
            wait_idle();
        end

        chk("scoreboard_empty", 128'(sbq.size()), 128'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
